// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend issue queue: pointer wrap-bit width and a lane-mask popcount.
package bp_be_pkg;

    localparam int bp_be_max_lanes_gp = 4;

    // Queue pointers carry one extra wrap bit above the index bits.
    localparam int bp_be_iq_wrap_bits_gp = 1;

    function automatic logic [2:0] bp_be_lane_popcount(input logic [bp_be_max_lanes_gp-1:0] mask);
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < bp_be_max_lanes_gp; i++) begin
            sum = sum + 3'(mask[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/bsg_circular_ptr.sv
// Modulo-slots circular pointer; slots_p must be a power of two, so wrap is plain truncation.
module bsg_circular_ptr #(
    parameter int slots_p   = 16,
    parameter int max_add_p = 1
) (
    input  logic                               clk,
    input  logic                               reset_n_i,
    input  logic [$clog2(max_add_p+1)-1:0]     add_i,
    output logic [$clog2(slots_p)-1:0]         o,
    output logic [$clog2(slots_p)-1:0]         n_o
);

    localparam int ptr_w_lp = $clog2(slots_p);

    logic [ptr_w_lp-1:0] ptr_reg;

    assign n_o = ptr_reg + ptr_w_lp'(add_i);
    assign o   = ptr_reg;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= n_o;
        end
    end

endmodule

// File: rtl/bp_be_multi_issue_queue.sv
// Multi-lane issue queue with speculative read pointer, commit checkpoint, rollback and clear.
// Optional same-cycle bypass when empty: define BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_multi_issue_queue
    import bp_be_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 16,
    parameter int lanes_p = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         clr_i,
    input  logic                         roll_i,
    input  logic [lanes_p-1:0]           deq_i,
    input  logic [lanes_p*width_p-1:0]   data_i,
    input  logic [lanes_p-1:0]           v_i,
    output logic                         ready_o,
    output logic [lanes_p*width_p-1:0]   data_o,
    output logic [lanes_p-1:0]           v_o,
    input  logic [lanes_p-1:0]           yumi_i,
    output logic [$clog2(els_p):0]       count_o
);

    localparam int ptr_w_lp  = $clog2(els_p) + bp_be_iq_wrap_bits_gp;
    localparam int addr_w_lp = $clog2(els_p);
    localparam int cadd_w_lp = $clog2(lanes_p + 1);

    logic [ptr_w_lp-1:0]  wptr_reg, rptr_reg, cptr_reg;
    logic [ptr_w_lp-1:0]  wptr_next, rptr_next, cptr_next;
    logic [ptr_w_lp-1:0]  rptr_target, wptr_target;
    logic [ptr_w_lp-1:0]  rptr_add, wptr_add;
    logic [cadd_w_lp-1:0] cptr_add;
    logic [ptr_w_lp-1:0]  enq_cnt, yumi_cnt, occupancy;
    logic                 bypass;

    logic [width_p-1:0]   mem [els_p];
    logic [lanes_p-1:0]   we, v_mem;
    logic [addr_w_lp-1:0] waddr [lanes_p];
    logic [addr_w_lp-1:0] raddr [lanes_p];

    assign count_o   = wptr_reg - cptr_reg;
    assign occupancy = wptr_reg - rptr_reg;
    assign ready_o   = ~clr_i & (count_o <= ptr_w_lp'(els_p - lanes_p));

    assign enq_cnt  = ready_o ? ptr_w_lp'(bp_be_lane_popcount(bp_be_max_lanes_gp'(v_i))) : '0;
    assign yumi_cnt = roll_i ? '0 : ptr_w_lp'(bp_be_lane_popcount(bp_be_max_lanes_gp'(yumi_i)));
    assign cptr_add = cadd_w_lp'(bp_be_lane_popcount(bp_be_max_lanes_gp'(deq_i)));

    // Rollback and clear are loads; they are expressed as a modular delta so the
    // circular pointer only ever adds.  Clear follows the already-rolled rptr.
    assign rptr_target = roll_i ? cptr_next : (rptr_reg + yumi_cnt);
    assign rptr_add    = rptr_target - rptr_reg;
    assign wptr_target = clr_i ? rptr_next : (wptr_reg + enq_cnt);
    assign wptr_add    = wptr_target - wptr_reg;

    bsg_circular_ptr #(.slots_p(2*els_p), .max_add_p(lanes_p)) cptr (
        .clk(clk_i), .reset_n_i(reset_n_i), .add_i(cptr_add), .o(cptr_reg), .n_o(cptr_next)
    );

    bsg_circular_ptr #(.slots_p(2*els_p), .max_add_p(2*els_p-1)) rptr (
        .clk(clk_i), .reset_n_i(reset_n_i), .add_i(rptr_add), .o(rptr_reg), .n_o(rptr_next)
    );

    bsg_circular_ptr #(.slots_p(2*els_p), .max_add_p(2*els_p-1)) wptr (
        .clk(clk_i), .reset_n_i(reset_n_i), .add_i(wptr_add), .o(wptr_reg), .n_o(wptr_next)
    );

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    assign bypass = (occupancy == '0);
`else
    assign bypass = 1'b0;
`endif

    for (genvar gi = 0; gi < lanes_p; gi++) begin : g_lane
        assign we[gi]    = ready_o & v_i[gi];
        assign waddr[gi] = addr_w_lp'(wptr_reg + ptr_w_lp'(gi));
        assign raddr[gi] = addr_w_lp'(rptr_reg + ptr_w_lp'(gi));
        assign v_mem[gi] = ~roll_i & (occupancy > ptr_w_lp'(gi));
        assign v_o[gi]   = bypass ? (~roll_i & v_i[gi] & ready_o) : v_mem[gi];
        // Invalid lanes read zero, which also gives zero output while in reset.
        assign data_o[gi*width_p +: width_p] = ~v_o[gi] ? '0
                                             : bypass ? data_i[gi*width_p +: width_p]
                                             : mem[raddr[gi]];
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < lanes_p; k++) begin
            if (we[k]) begin
                mem[waddr[k]] <= data_i[k*width_p +: width_p];
            end
        end
    end

`ifndef SYNTHESIS
    function automatic logic lane_mask_ok(input logic [lanes_p-1:0] m);
        return (m & (m + lanes_p'(1))) == '0;
    endfunction

    a_v_contig:    assert property (@(posedge clk_i) disable iff (!reset_n_i) lane_mask_ok(v_i));
    a_yumi_contig: assert property (@(posedge clk_i) disable iff (!reset_n_i) lane_mask_ok(yumi_i));
    a_deq_contig:  assert property (@(posedge clk_i) disable iff (!reset_n_i) lane_mask_ok(deq_i));
    a_yumi_valid:  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    roll_i || ((yumi_i & ~v_o) == '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    (wptr_next - cptr_next) <= ptr_w_lp'(els_p));
`endif

endmodule

// File: tb/tb_bp_be_multi_issue_queue.sv
// Randomized and directed bench for bp_be_multi_issue_queue (els_p=8, lanes_p=2, bypass off).
module tb_bp_be_multi_issue_queue;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_i = 1'b0, roll_i = 1'b0;
    logic [1:0]    deq_i = '0, v_i = '0, yumi_i = '0;
    logic [2*W-1:0] data_i = '0;
    logic          ready_o;
    logic [2*W-1:0] data_o;
    logic [1:0]    v_o;
    logic [3:0]    count_o;

    bp_be_multi_issue_queue #(.width_p(W), .els_p(8), .lanes_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .clr_i(clr_i), .roll_i(roll_i),
        .deq_i(deq_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded absolute positions, payload keyed by position.
    int w = 0, r = 0, c = 0;
    logic [W-1:0] mdata [int];
    bit saw_wrap0 = 0, saw_wrap1 = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mask_of(input int n);
        return (n <= 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    endfunction

    function automatic int pc(input logic [1:0] m);
        return int'(m[0]) + int'(m[1]);
    endfunction

    function automatic int min2(input int a);
        return (a < 2) ? a : 2;
    endfunction

    task automatic run_cycle(input logic [1:0] v, input logic [1:0] y, input logic [1:0] dq,
                             input logic clr, input logic roll);
        int occ, enq, nc;
        logic [1:0] ev;
        logic exp_ready;
        logic [2*W-1:0] d;
        d = {16'($urandom), 16'($urandom)};
        v_i = v; data_i = d; yumi_i = y; deq_i = dq; clr_i = clr; roll_i = roll;
        #1;
        occ = w - r;
        exp_ready = !clr && ((8 - (w - c)) >= 2);
        ev[0] = !roll && (occ > 0);
        ev[1] = !roll && (occ > 1);
        check_val("ready_o", 64'(ready_o), 64'(exp_ready));
        check_val("count_o", 64'(count_o), 64'(w - c));
        check_val("v_o", 64'(v_o), 64'(ev));
        for (int k = 0; k < 2; k++) begin
            if (ev[k]) check_val("data_o", 64'(data_o[k*W +: W]), 64'(mdata[r + k]));
        end
        @(posedge clk);
        #1;
        enq = exp_ready ? pc(v) : 0;
        for (int k = 0; k < enq; k++) mdata[w + k] = d[k*W +: W];
        nc = c + pc(dq);
        r  = roll ? nc : r + pc(y);
        w  = clr ? r : w + enq;
        c  = nc;
        check_val("wptr", 64'(dut.wptr_reg), 64'(w % 16));
        check_val("rptr", 64'(dut.rptr_reg), 64'(r % 16));
        check_val("cptr", 64'(dut.cptr_reg), 64'(c % 16));
        if (dut.wptr_reg[3]) saw_wrap1 = 1; else saw_wrap0 = 1;
        $display("cyc v=%b y=%b dq=%b clr=%b roll=%b -> w=%0d r=%0d c=%0d", v, y, dq, clr, roll, w, r, c);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        v_i = '0; yumi_i = '0; deq_i = '0; clr_i = 1'b0; roll_i = 1'b0;
    endtask

    // Asserts reset without waiting for an edge and checks outputs immediately.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_val("rst_count", 64'(count_o), 64'(0));
        check_val("rst_v_o", 64'(v_o), 64'(0));
        check_val("rst_ready", 64'(ready_o), 64'(1));
        check_val("rst_data", 64'(data_o), 64'(0));
        w = 0; r = 0; c = 0;
        mdata.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_cycle();
        logic roll, clr;
        int ny, nd;
        roll = ($urandom % 16) == 0;
        clr  = ($urandom % 20) == 0;
        ny = roll ? 0 : $urandom_range(0, min2(w - r));
        nd = $urandom_range(0, min2(r - c));
        run_cycle(mask_of($urandom_range(0, 2)), mask_of(ny), mask_of(nd), clr, roll);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_val("init_count", 64'(count_o), 64'(0));
        check_val("init_ready", 64'(ready_o), 64'(1));
        check_val("init_v_o", 64'(v_o), 64'(0));
        reset_n = 1'b1;

        // Two-then-one enqueue, one-cycle latency.
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b00, 2'b00, 0, 0);

        // Fill to 7, ready drops, then read and commit two.
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b11, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b00, 2'b11, 0, 0);
        run_cycle(2'b00, 2'b00, 2'b00, 0, 0);

        // Rollback to the checkpoint.
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b11, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b11, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b00, 2'b01, 0, 0);
        run_cycle(2'b00, 2'b00, 2'b01, 0, 1);
        check_val("roll_rptr", 64'(dut.rptr_reg), 64'(2));
        run_cycle(2'b00, 2'b00, 2'b00, 0, 0);

        // Clear discards unread entries.
        do_reset();
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b11, 2'b00, 0, 0);
        run_cycle(2'b00, 2'b01, 2'b00, 1, 0);
        check_val("clr_wptr", 64'(dut.wptr_reg), 64'(3));
        run_cycle(2'b00, 2'b00, 2'b00, 0, 0);

        // Steady two-in two-out stream across the index wrap.
        do_reset();
        saw_wrap0 = 0; saw_wrap1 = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(2'b11, mask_of(min2(w - r)), mask_of(min2(r - c)), 0, 0);
        end
        check_val("wrap_toggle", 64'(saw_wrap0 && saw_wrap1), 64'(1));

        // Asynchronous reset mid-burst.
        do_reset();
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b11, 2'b00, 2'b00, 0, 0);
        run_cycle(2'b01, 2'b00, 2'b00, 0, 0);
        check_val("burst_count", 64'(count_o), 64'(5));
        do_reset();

        for (int i = 0; i < 400; i++) random_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_multi_issue_queue.md
BP_BE_MULTI_ISSUE_QUEUE -- requirements
Module: bp_be_multi_issue_queue

Interface
REQ-001 SHALL have parameter width_p, default 64: entry payload width in bits.
REQ-002 SHALL have parameter els_p, default 16: queue depth; power of two, els_p >= 2*lanes_p.
REQ-003 SHALL have parameter lanes_p, default 2: enqueue/read/commit lanes per cycle, 1..4.
REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clr_i, input, 1: discard all unread entries.
REQ-007 SHALL have port roll_i, input, 1: rewind read pointer to the checkpoint.
REQ-008 SHALL have port deq_i, input, lanes_p: commit-lane valids, contiguous from lane 0.
REQ-009 SHALL have port data_i, input, lanes_p*width_p: enqueue payload, lane 0 in the LSBs.
REQ-010 SHALL have port v_i, input, lanes_p: enqueue valids, contiguous from lane 0.
REQ-011 SHALL have port ready_o, output, 1: lanes_p free slots exist and clr_i is low.
REQ-012 SHALL have port data_o, output, lanes_p*width_p: entries at rptr+0 .. rptr+lanes_p-1.
REQ-013 SHALL have port v_o, output, lanes_p: per-lane read valid.
REQ-014 SHALL have port yumi_i, input, lanes_p: consume, contiguous from lane 0, subset of v_o.
REQ-015 SHALL have port count_o, output, clog2(els_p)+1: entries between cptr and wptr.

Function
REQ-016 SHALL keep wptr, rptr and cptr, each clog2(els_p)+1 bits (wrap bit as MSB); entries SHALL lie in order cptr <= rptr <= wptr.
REQ-017 SHALL enqueue popcount(v_i) entries when ready_o is high, writing lane k at wptr+k; wptr SHALL advance by that count.
REQ-018 SHALL drive ready_o = ~clr_i & (els_p - count_o >= lanes_p).
REQ-019 SHALL drive v_o[k] = ~roll_i & (wptr - rptr > k); data_o lane k SHALL read address rptr+k mod els_p.
REQ-020 SHALL advance rptr by popcount(yumi_i) when roll_i is low.
REQ-021 SHALL advance cptr by popcount(deq_i); the entries behind cptr are freed.
REQ-022 SHALL, on roll_i, set rptr_next = cptr + popcount(deq_i) and ignore yumi_i in that cycle.
REQ-023 SHALL, on clr_i, set wptr_next = rptr_next; enqueue is blocked in that cycle.
REQ-024 SHALL apply clr_i and roll_i together as: rptr := cptr_next, then wptr := cptr_next.
REQ-025 SHALL compute all pointer arithmetic modulo 2*els_p; full is when count_o == els_p, empty is when wptr == rptr.
REQ-026 SHALL treat non-contiguous v_i, yumi_i or deq_i, or a yumi beyond v_o, as illegal; assertions SHALL flag these under simulation only.

Reset
REQ-027 SHALL, while reset_n_i is low, asynchronously force wptr, rptr and cptr to 0; v_o, count_o and data_o SHALL then read 0.
REQ-028 SHALL give ready_o the value 1 during reset and in the first cycle after release.
REQ-029 SHALL NOT reset the storage array; any operation in flight is discarded.

Configuration
REQ-030 SHALL, when BP_BE_ISSUE_QUEUE_BYPASS_EN is defined and the queue is empty, drive v_o = v_i & ready_o and data_o = data_i in the same cycle, while still writing the entries; a same-cycle yumi_i SHALL advance rptr.
REQ-031 SHALL, when BP_BE_ISSUE_QUEUE_BYPASS_EN is undefined, give enqueue-to-v_o a latency of exactly 1 cycle.

Structure
REQ-032 SHALL place the pointer-width localparam and the popcount function for lane masks in bp_be_pkg.
REQ-033 SHALL instantiate bsg_circular_ptr for each of the three pointers, with max_add_p = 2*els_p-1 for wptr and rptr and lanes_p for cptr.
REQ-034 SHALL use a register array with lanes_p write ports and lanes_p read ports as storage.

Verification (els_p=8, lanes_p=2, bypass off)
REQ-035 SHALL cover: enqueue A,B (v_i=11), then C (v_i=01) -> next cycle v_o=11, data_o={B,A}; count_o=3.
REQ-036 SHALL cover: fill 8 entries with no deq -> ready_o=0 at count_o=7; ready_o=1 again after deq_i=11.
REQ-037 SHALL cover: enqueue 6, yumi 4, deq 1, then roll_i=1 with deq_i=01 -> rptr=cptr=2, v_o=0 that cycle, the entry at index 2 is re-presented next cycle.
REQ-038 SHALL cover: enqueue 5, yumi 2, clr_i=1 with yumi_i=01 -> wptr=rptr=3, v_o=00 next cycle, ready_o=0 during the clr cycle.
REQ-039 SHALL cover: wrap — 20 cycles at 2 in and 2 out -> data order is preserved across index 7 to 0 and the wrap bit toggles.
REQ-040 SHALL cover: assert reset_n_i low mid-burst at count_o=5 -> count_o=0, v_o=00 and ready_o=1 immediately, without waiting for a clock edge.
